// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and constants for the two-way data cache.
package dcache_pkg;

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} dc_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;

    // Tag storage is sized for the widest tag; narrower tags are zero-extended.
    localparam int TAG_MAX = 32;

    typedef struct packed {
        logic               valid;
        logic               dirty;
        logic [TAG_MAX-1:0] tag;
        logic [31:0]        data;
    } dc_way_t;

endpackage

// File: rtl/dcache_byte_lane.sv
// dcache_byte_lane: load extraction and store merge by funct3 and byte offset.
module dcache_byte_lane
    import dcache_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merge
);

    logic [7:0] w_byte;

    always_comb begin
        w_byte = i_word[{i_offset, 3'b000} +: 8];
        o_load = (i_funct3 == F3_LW) ? i_word :
                 (i_funct3 == F3_LB) ? {{24{w_byte[7]}}, w_byte} : {24'b0, w_byte};
        o_merge = i_word;
        if (i_funct3 == F3_LW)
            o_merge = i_wdata;
        else
            o_merge[{i_offset, 3'b000} +: 8] = i_wdata[7:0];
    end

endmodule

// File: rtl/dcache_2way.sv
// dcache_2way: two-way set-associative write-back, write-allocate data cache
// with one-word lines, per-set LRU and a blocking miss FSM.
module dcache_2way
    import dcache_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SETS   = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  rd_en_i,
    input  logic                  wr_en_i,
    input  logic [2:0]            funct3_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  stall_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_ack_i
);

    localparam int SET_BITS = $clog2(NUM_SETS);
    localparam int TAG_BITS = ADDR_WIDTH - SET_BITS - 2;

    dc_state_e           r_state, w_next;
    dc_way_t             r_way [2][NUM_SETS];
    logic [NUM_SETS-1:0] r_lru;

    logic [SET_BITS-1:0]   w_set;
    logic [TAG_BITS-1:0]   w_tag;
    dc_way_t               w_e0, w_e1, w_ve;
    logic                  w_hit0, w_hit1, w_hit, w_hway, w_vic, w_req, w_miss;
    logic                  w_do_hit, w_fill;
    logic [31:0]           w_load, w_merge;
    logic [ADDR_WIDTH-1:0] w_wb_addr, w_rf_addr;

    assign w_set     = addr_i[SET_BITS+1:2];
    assign w_tag     = addr_i[ADDR_WIDTH-1:SET_BITS+2];
    assign w_e0      = r_way[0][w_set];
    assign w_e1      = r_way[1][w_set];
    assign w_hit0    = w_e0.valid && (w_e0.tag == TAG_MAX'(w_tag));
    assign w_hit1    = w_e1.valid && (w_e1.tag == TAG_MAX'(w_tag));
    assign w_hit     = w_hit0 || w_hit1;
    assign w_hway    = w_hit1;
    // Arrays stay frozen during WRITEBACK/REFILL, so the victim is stable without a register.
    assign w_vic     = !w_e0.valid ? 1'b0 : !w_e1.valid ? 1'b1 : r_lru[w_set];
    assign w_ve      = w_vic ? w_e1 : w_e0;
    assign w_req     = rd_en_i || wr_en_i;
    assign w_miss    = w_req && !w_hit;
    assign w_do_hit  = (r_state == IDLE) && w_req && w_hit;
    assign w_fill    = (r_state == REFILL) && mem_ack_i;
    assign w_wb_addr = ADDR_WIDTH'({w_ve.tag, w_set, 2'b00});
    assign w_rf_addr = {addr_i[ADDR_WIDTH-1:2], 2'b00};

    dcache_byte_lane u_lane (
        .i_funct3 (funct3_i),
        .i_offset (addr_i[1:0]),
        .i_word   (w_hway ? w_e1.data : w_e0.data),
        .i_wdata  (wdata_i),
        .o_load   (w_load),
        .o_merge  (w_merge)
    );

    always_comb begin
        w_next      = (r_state == IDLE) ? (w_miss ? ((w_ve.valid && w_ve.dirty) ? WRITEBACK : REFILL) : IDLE) :
                      mem_ack_i ? ((r_state == WRITEBACK) ? REFILL : IDLE) : r_state;
        stall_o     = rst_ni && ((r_state != IDLE) || w_miss);
        mem_req_o   = r_state != IDLE;
        mem_we_o    = r_state == WRITEBACK;
        mem_addr_o  = (r_state == WRITEBACK) ? w_wb_addr : (r_state == REFILL) ? w_rf_addr : '0;
        mem_wdata_o = (r_state == WRITEBACK) ? w_ve.data : '0;
        rdata_o     = ((r_state == IDLE) && w_hit) ? w_load : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_lru   <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                r_way[0][s].valid <= 1'b0;
                r_way[0][s].dirty <= 1'b0;
                r_way[1][s].valid <= 1'b0;
                r_way[1][s].dirty <= 1'b0;
            end
        end else begin
            r_state <= w_next;
            if (w_do_hit) begin
                r_lru[w_set] <= ~w_hway;
                if (wr_en_i) begin
                    r_way[w_hway][w_set].data  <= w_merge;
                    r_way[w_hway][w_set].dirty <= 1'b1;
                end
            end
            if (w_fill) begin
                r_way[w_vic][w_set] <= '{valid: 1'b1, dirty: 1'b0, tag: TAG_MAX'(w_tag), data: mem_rdata_i};
                r_lru[w_set]        <= ~w_vic;
            end
        end
    end

endmodule
